mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port 32-bit SRAM between instruction fetch (I port, read-only) and the
//  load/store stage (D port, read/write). Sits between the pipeline and the unified memory.
//  Arbitrates requests, runs the SRAM read-latency counter and returns read data with a valid pulse.
//  D has priority; a starvation counter forces an I grant after repeated losses.
// PARAMETERS
//  AW          16  SRAM byte-address width
//  RD_LAT      1   SRAM read latency in cycles (legal values 1..3)
//  STARVE_MAX  3   consecutive I losses that force the next grant to I (legal values 1..15)
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   synchronous, active-low reset (0 = reset)
//  i_req      in   1   fetch read request; held until i_gnt
//  i_addr     in   AW  fetch address
//  i_gnt      out  1   I request accepted this cycle (combinational)
//  i_rvalid   out  1   one-cycle pulse: i_rdata valid
//  i_rdata    out  32  fetch data (registered)
//  d_req      in   1   load/store request; held until d_gnt
//  d_w_en     in   4   byte write enables; 4'b0000 = load
//  d_addr     in   AW  data address
//  d_wdata    in   32  store data
//  d_gnt      out  1   D request accepted this cycle (combinational)
//  d_rvalid   out  1   one-cycle pulse: d_rdata valid (loads only)
//  d_rdata    out  32  load data (registered)
//  mem_w_en   out  4   SRAM byte write enables
//  mem_addr   out  AW  SRAM address
//  mem_wdata  out  32  SRAM write data
//  mem_rdata  in   32  SRAM read data, valid RD_LAT cycles after address
//  busy       out  1   read in flight (state != IDLE)
// BEHAVIOUR
//  Reset (rst=0 at edge): state=IDLE, lat_cnt=0, starve_cnt=0, i/d_rdata=0. While rst=0: gnt,
//   rvalid, mem_w_en forced 0. In-flight read is dropped; no rvalid issued after reset.
//  States: IDLE, RD_I, RD_D. lat_cnt counts RD_LAT-1 down to 0 in RD_x.
//  Accept window: state==IDLE, or RD_x with lat_cnt==0 (back-to-back reads, one per RD_LAT cycles).
//  Arbitration in accept window: only one req -> that port wins; both -> D wins unless
//   starve_cnt==STARVE_MAX, then I wins. Exactly one gnt per accept cycle; none outside window.
//  Winner's addr/w_en/wdata drive mem_* combinationally in accept cycle; otherwise mem_w_en=0,
//   mem_addr = last driven address, mem_wdata = 0.
//  D store (d_w_en!=0): single cycle; mem_w_en=d_w_en; no d_rvalid; next state IDLE.
//  Read grant: next state RD_I/RD_D, lat_cnt=RD_LAT-1. When lat_cnt==0 in RD_x: x_rvalid=1,
//   x_rdata<=mem_rdata captured at that edge, held until next capture; then next state per new grant
//   (RD_y) or IDLE.
//  starve_cnt: +1 (saturate at STARVE_MAX) when accept window, i_req=1 and D wins; clears on i_gnt
//   or when i_req=0 in an accept window; unchanged outside window.
//  Simultaneous rvalid and new grant in same cycle is legal and required.
//  Requester dropping req before gnt is legal; no state change.
// STRUCTURE
//  Package mem_arb_pkg: state enum (IDLE/RD_I/RD_D), W_EN_W=4, DATA_W=32, W_EN_LOAD=4'b0000.
//  Sub-module arb_starve_ctr: saturating starve_cnt with inc/clr inputs and at_max output.
//  Remaining FSM, latency counter and output muxing stay in mem_arbiter.
// TESTING
//  RD_LAT=1: i_req, i_addr=16'h0010, mem returns 32'h00A0_0093 -> i_gnt cycle 0, i_rvalid
//   cycle 1, i_rdata=32'h00A0_0093.
//  Store: d_req, d_w_en=4'b0011, d_addr=16'h0100, d_wdata=32'hDEAD_BEEF -> d_gnt and
//   mem_w_en=4'b0011 same cycle, no d_rvalid, busy stays 0.
//  Both req held continuously, d_w_en=0, STARVE_MAX=3, RD_LAT=1 -> grant order D,D,D,I,D,D,D,I.
//  RD_LAT=2 back-to-back I reads at 0x0,0x4 -> i_rvalid cycles 2 and 4, correct data each.
//  rst=0 asserted while in RD_D with lat_cnt=1 -> no d_rvalid, d_rdata=0, busy=0 after edge.
//  i_req alone dropped before accept window (during RD_D) -> no i_gnt, starve_cnt unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the I/D memory arbiter
package mem_arb_pkg;

    localparam int W_EN_W = 4;
    localparam int DATA_W = 32;

    localparam logic [W_EN_W-1:0] W_EN_LOAD = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and SRAM signal bundle for the arbiter
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = 16
) ();

    // Instruction fetch port (read only)
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    // Load/store port
    logic              d_req;
    logic [W_EN_W-1:0] d_w_en;
    logic [AW-1:0]     d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Single-port SRAM side
    logic [W_EN_W-1:0] mem_w_en;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  i_req, i_addr,
        input  d_req, d_w_en, d_addr, d_wdata,
        input  mem_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_w_en, mem_addr, mem_wdata,
        output busy
    );

    // Pipeline plus SRAM side
    modport master (
        output i_req, i_addr,
        output d_req, d_w_en, d_addr, d_wdata,
        output mem_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_w_en, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of consecutive fetch losses
module arb_starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [3:0] MAX_CNT = 4'(STARVE_MAX);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Clear wins over increment; increment stops at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Loss counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port SRAM between fetch and load/store
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [1:0]        lat_cnt_q;
    logic [1:0]        lat_cnt_d;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [AW-1:0]     last_addr_q;

    logic              accept;
    logic              at_max;
    logic              i_win;
    logic              d_win;
    logic              d_store;
    logic              rd_done;
    logic [AW-1:0]     mem_addr_c;

    // A new request can be taken when idle or in the last cycle of a read,
    // which lets reads issue back to back at one per RD_LAT cycles.
    assign accept  = rst && ((state_q == IDLE) || (lat_cnt_q == 2'd0));

    // D has priority unless fetch has lost STARVE_MAX times in a row.
    assign i_win   = accept && bus.i_req && (!bus.d_req || at_max);
    assign d_win   = accept && bus.d_req && !i_win;
    assign d_store = d_win && (bus.d_w_en != W_EN_LOAD);

    // Read data is on mem_rdata in the final latency cycle.
    assign rd_done = rst && (state_q != IDLE) && (lat_cnt_q == 2'd0);

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (accept && bus.i_req && d_win),
        .clr_i    (accept && (i_win || !bus.i_req)),
        .at_max_o (at_max)
    );

    // Next state: a new grant overrides read completion; stores finish in one cycle.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        if (i_win) begin
            state_d   = RD_I;
            lat_cnt_d = LAT_INIT;
        end else if (d_win && !d_store) begin
            state_d   = RD_D;
            lat_cnt_d = LAT_INIT;
        end else if (d_store || rd_done) begin
            state_d   = IDLE;
            lat_cnt_d = 2'd0;
        end else if (state_q != IDLE) begin
            lat_cnt_d = lat_cnt_q - 2'd1;
        end
    end

    // SRAM address follows the winner and otherwise holds the last one driven.
    always_comb begin
        mem_addr_c = last_addr_q;
        if (i_win) begin
            mem_addr_c = bus.i_addr;
        end else if (d_win) begin
            mem_addr_c = bus.d_addr;
        end
    end

    // FSM, latency counter and read-data capture; reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 2'd0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            last_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            if (rd_done && (state_q == RD_I)) begin
                i_rdata_q <= bus.mem_rdata;
            end
            if (rd_done && (state_q == RD_D)) begin
                d_rdata_q <= bus.mem_rdata;
            end
            if (i_win || d_win) begin
                last_addr_q <= mem_addr_c;
            end
        end
    end

    assign bus.i_gnt     = i_win;
    assign bus.d_gnt     = d_win;
    assign bus.i_rvalid  = rd_done && (state_q == RD_I);
    assign bus.d_rvalid  = rd_done && (state_q == RD_D);
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_w_en  = d_win ? bus.d_w_en : W_EN_LOAD;
    assign bus.mem_wdata = d_win ? bus.d_wdata : '0;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_arbiter_if #(.AW(16)) ifa ();
    mem_arbiter_if #(.AW(16)) ifb ();

    mem_arbiter #(.AW(16), .RD_LAT(1), .STARVE_MAX(3)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    mem_arbiter #(.AW(16), .RD_LAT(2), .STARVE_MAX(3)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [15:0] a);
        if (a == 16'h0010) return 32'h00A0_0093;
        return {16'hC0DE ^ a, a};
    endfunction

    // SRAM models: data appears RD_LAT cycles after the address.
    logic [15:0] a_p1;
    logic [15:0] b_p1;
    logic [15:0] b_p2;
    always @(posedge clk) begin
        a_p1 <= ifa.mem_addr;
        b_p1 <= ifb.mem_addr;
        b_p2 <= b_p1;
    end
    assign ifa.mem_rdata = pat(a_p1);
    assign ifb.mem_rdata = pat(b_p2);

    logic [31:0] a_iq[$];
    logic [31:0] a_dq[$];
    logic [31:0] b_iq[$];
    logic [31:0] b_dq[$];
    logic [31:0] a_iexp, a_dexp, b_iexp, b_dexp;
    logic        a_ipend, a_dpend, b_ipend, b_dpend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic r, input logic ir, input logic [15:0] ia,
                          input logic dr, input logic [3:0] dw, input logic [15:0] da,
                          input logic [31:0] dd);
        @(posedge clk);
        #1;
        rst = r;
        ifa.i_req = ir; ifa.i_addr = ia;
        ifa.d_req = dr; ifa.d_w_en = dw; ifa.d_addr = da; ifa.d_wdata = dd;
        #2;
        if (a_ipend) begin chk("a_i_rdata_sb", ifa.i_rdata, a_iexp); a_ipend = 1'b0; end
        if (a_dpend) begin chk("a_d_rdata_sb", ifa.d_rdata, a_dexp); a_dpend = 1'b0; end
        if (!r) begin a_iq.delete(); a_dq.delete(); end
        if (ifa.i_rvalid) begin
            chk("a_i_rvalid_expected", 32'(a_iq.size() != 0), 1);
            if (a_iq.size() != 0) begin a_iexp = a_iq.pop_front(); a_ipend = 1'b1; end
        end
        if (ifa.d_rvalid) begin
            chk("a_d_rvalid_expected", 32'(a_dq.size() != 0), 1);
            if (a_dq.size() != 0) begin a_dexp = a_dq.pop_front(); a_dpend = 1'b1; end
        end
        if (ifa.i_gnt) a_iq.push_back(pat(ia));
        if (ifa.d_gnt && (dw == 4'b0000)) a_dq.push_back(pat(da));
    endtask

    task automatic step_b(input logic r, input logic ir, input logic [15:0] ia,
                          input logic dr, input logic [3:0] dw, input logic [15:0] da,
                          input logic [31:0] dd);
        @(posedge clk);
        #1;
        rst = r;
        ifb.i_req = ir; ifb.i_addr = ia;
        ifb.d_req = dr; ifb.d_w_en = dw; ifb.d_addr = da; ifb.d_wdata = dd;
        #2;
        if (b_ipend) begin chk("b_i_rdata_sb", ifb.i_rdata, b_iexp); b_ipend = 1'b0; end
        if (b_dpend) begin chk("b_d_rdata_sb", ifb.d_rdata, b_dexp); b_dpend = 1'b0; end
        if (!r) begin b_iq.delete(); b_dq.delete(); end
        if (ifb.i_rvalid) begin
            chk("b_i_rvalid_expected", 32'(b_iq.size() != 0), 1);
            if (b_iq.size() != 0) begin b_iexp = b_iq.pop_front(); b_ipend = 1'b1; end
        end
        if (ifb.d_rvalid) begin
            chk("b_d_rvalid_expected", 32'(b_dq.size() != 0), 1);
            if (b_dq.size() != 0) begin b_dexp = b_dq.pop_front(); b_dpend = 1'b1; end
        end
        if (ifb.i_gnt) b_iq.push_back(pat(ia));
        if (ifb.d_gnt && (dw == 4'b0000)) b_dq.push_back(pat(da));
    endtask

    initial begin
        logic exp_i;
        checks = 0; failures = 0;
        a_ipend = 0; a_dpend = 0; b_ipend = 0; b_dpend = 0;
        a_iexp = 0; a_dexp = 0; b_iexp = 0; b_dexp = 0;
        rst = 1'b0;
        ifa.i_req = 0; ifa.i_addr = 0; ifa.d_req = 0; ifa.d_w_en = 0; ifa.d_addr = 0; ifa.d_wdata = 0;
        ifb.i_req = 0; ifb.i_addr = 0; ifb.d_req = 0; ifb.d_w_en = 0; ifb.d_addr = 0; ifb.d_wdata = 0;

        // Reset: requests present but nothing granted or written
        step_a(0, 1, 16'h0010, 1, 4'hF, 16'h0100, 32'h1234_5678);
        chk("rst_i_gnt", ifa.i_gnt, 0);
        chk("rst_d_gnt", ifa.d_gnt, 0);
        chk("rst_mem_w_en", ifa.mem_w_en, 0);
        step_a(0, 0, 0, 0, 0, 0, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_i_rdata", ifa.i_rdata, 0);
        chk("rst_d_rdata", ifa.d_rdata, 0);
        chk("rst_i_rvalid", ifa.i_rvalid, 0);

        // Single fetch read, RD_LAT=1
        step_a(1, 1, 16'h0010, 0, 0, 0, 0);
        chk("rd_i_gnt", ifa.i_gnt, 1);
        chk("rd_d_gnt", ifa.d_gnt, 0);
        chk("rd_mem_addr", ifa.mem_addr, 16'h0010);
        chk("rd_busy_c0", ifa.busy, 0);
        step_a(1, 0, 0, 0, 0, 0, 0);
        chk("rd_i_rvalid_c1", ifa.i_rvalid, 1);
        chk("rd_busy_c1", ifa.busy, 1);
        step_a(1, 0, 0, 0, 0, 0, 0);
        chk("rd_i_rdata", ifa.i_rdata, 32'h00A0_0093);
        chk("rd_i_rvalid_c2", ifa.i_rvalid, 0);
        chk("rd_busy_c2", ifa.busy, 0);

        // Store: single cycle, no read-back
        step_a(1, 0, 0, 1, 4'b0011, 16'h0100, 32'hDEAD_BEEF);
        chk("st_d_gnt", ifa.d_gnt, 1);
        chk("st_mem_w_en", ifa.mem_w_en, 4'b0011);
        chk("st_mem_addr", ifa.mem_addr, 16'h0100);
        chk("st_mem_wdata", ifa.mem_wdata, 32'hDEAD_BEEF);
        chk("st_busy_c0", ifa.busy, 0);
        step_a(1, 0, 0, 0, 0, 0, 0);
        chk("st_d_rvalid", ifa.d_rvalid, 0);
        chk("st_busy_c1", ifa.busy, 0);
        chk("st_idle_w_en", ifa.mem_w_en, 0);
        chk("st_idle_addr_hold", ifa.mem_addr, 16'h0100);
        chk("st_idle_wdata", ifa.mem_wdata, 0);

        // Both requesting continuously: D,D,D,I,D,D,D,I
        for (int k = 0; k < 8; k++) begin
            step_a(1, 1, 16'h0020, 1, 4'b0000, 16'h0040, 0);
            exp_i = (k == 3) || (k == 7);
            chk("starve_i_gnt", ifa.i_gnt, 32'(exp_i));
            chk("starve_d_gnt", ifa.d_gnt, 32'(!exp_i));
        end
        step_a(1, 0, 0, 0, 0, 0, 0);
        step_a(1, 0, 0, 0, 0, 0, 0);
        step_a(1, 0, 0, 0, 0, 0, 0);
        chk("a_iq_drained", a_iq.size(), 0);
        chk("a_dq_drained", a_dq.size(), 0);

        // RD_LAT=2: back-to-back fetches at 0x0 and 0x4
        step_b(1, 1, 16'h0000, 0, 0, 0, 0);
        chk("b2b_gnt_c0", ifb.i_gnt, 1);
        step_b(1, 1, 16'h0004, 0, 0, 0, 0);
        chk("b2b_gnt_c1", ifb.i_gnt, 0);
        chk("b2b_rvalid_c1", ifb.i_rvalid, 0);
        chk("b2b_busy_c1", ifb.busy, 1);
        step_b(1, 1, 16'h0004, 0, 0, 0, 0);
        chk("b2b_rvalid_c2", ifb.i_rvalid, 1);
        chk("b2b_gnt_c2", ifb.i_gnt, 1);
        step_b(1, 0, 0, 0, 0, 0, 0);
        chk("b2b_rvalid_c3", ifb.i_rvalid, 0);
        chk("b2b_rdata_0", ifb.i_rdata, 32'hC0DE_0000);
        step_b(1, 0, 0, 0, 0, 0, 0);
        chk("b2b_rvalid_c4", ifb.i_rvalid, 1);
        step_b(1, 0, 0, 0, 0, 0, 0);
        chk("b2b_rdata_4", ifb.i_rdata, 32'hC0DA_0004);
        chk("b2b_busy_c5", ifb.busy, 0);

        // Fetch drops its request outside the accept window
        step_b(1, 1, 16'h0008, 1, 0, 16'h0040, 0);
        chk("drop_d_gnt", ifb.d_gnt, 1);
        chk("drop_i_gnt_c0", ifb.i_gnt, 0);
        step_b(1, 0, 0, 0, 0, 0, 0);
        chk("drop_i_gnt_c1", ifb.i_gnt, 0);
        chk("drop_starve_c1", u_dut_b.u_starve.cnt_q, 1);
        step_b(1, 0, 0, 0, 0, 0, 0);
        chk("drop_d_rvalid", ifb.d_rvalid, 1);
        chk("drop_starve_c2", u_dut_b.u_starve.cnt_q, 1);
        step_b(1, 0, 0, 0, 0, 0, 0);
        chk("drop_d_rdata", ifb.d_rdata, 32'hC09E_0040);
        chk("drop_starve_cleared", u_dut_b.u_starve.cnt_q, 0);

        // Reset while a load is one cycle from completing
        step_b(1, 0, 0, 1, 0, 16'h0044, 0);
        chk("rstfl_d_gnt", ifb.d_gnt, 1);
        step_b(0, 0, 0, 0, 0, 0, 0);
        chk("rstfl_d_rvalid_in_rst", ifb.d_rvalid, 0);
        chk("rstfl_d_gnt_in_rst", ifb.d_gnt, 0);
        step_b(1, 0, 0, 0, 0, 0, 0);
        chk("rstfl_busy", ifb.busy, 0);
        chk("rstfl_d_rdata", ifb.d_rdata, 0);
        chk("rstfl_d_rvalid_c1", ifb.d_rvalid, 0);
        step_b(1, 0, 0, 0, 0, 0, 0);
        chk("rstfl_d_rvalid_c2", ifb.d_rvalid, 0);
        chk("rstfl_d_rdata_c2", ifb.d_rdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
